// File: rtl/dbctr_core_if.sv
// Button/operand/result bundle for the debounced up/down/load counter.
interface dbctr_core_if #(
  parameter int unsigned WIDTH = 4
);
  logic             up;
  logic             down;
  logic             load;
  logic             clear;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] counter;
  logic             ack;

  // Stimulus side: drives buttons and load operand, observes counter/ack.
  modport master (
    output up, down, load, clear, value,
    input  counter, ack
  );

  // Counter side.
  modport slave (
    input  up, down, load, clear, value,
    output counter, ack
  );
endinterface

// File: rtl/dbctr_core.sv
// Debounced up/down/load counter with synchronous clear and a one-cycle ack per event.
// Each button must be sampled high for HOLD_CYCLES consecutive edges to fire; it fires once
// per assertion because its debounce counter saturates past the firing value.
module dbctr_core #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned WIDTH       = 4
) (
  input logic         clock,
  input logic         reset_n,
  dbctr_core_if.slave bus
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HoldMax = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] FireAt  = CW'(HOLD_CYCLES - 1);

  // Button index: 0 = up, 1 = down, 2 = load.
  logic [2:0]          btn;
  logic [2:0]          fire;
  logic [2:0][CW-1:0]  db_q, db_d;
  logic [WIDTH-1:0]    counter_q, counter_d;
  logic                ack_q, ack_d;
  logic                clear_q;

  assign btn = {bus.load, bus.down, bus.up};

  // Debounce counters: count consecutive highs, saturate, zero on low or while clear is high.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      fire[i] = 1'b0;
      db_d[i] = '0;
      if (!bus.clear && btn[i]) begin
        fire[i] = (db_q[i] == FireAt);
        db_d[i] = (db_q[i] == HoldMax) ? HoldMax : db_q[i] + CW'(1);
      end
    end
  end

  // Counter update: clear beats every button; among buttons load > up > down.
  always_comb begin
    counter_d = counter_q;
    ack_d     = 1'b0;
    if (bus.clear) begin
      counter_d = '0;
      ack_d     = !clear_q;  // only the first edge of a clear assertion acks
    end else if (fire[2]) begin
      counter_d = bus.value;
      ack_d     = 1'b1;
    end else if (fire[0]) begin
      counter_d = counter_q + WIDTH'(1);
      ack_d     = 1'b1;
    end else if (fire[1]) begin
      counter_d = counter_q - WIDTH'(1);
      ack_d     = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_q      <= '0;
      counter_q <= '0;
      ack_q     <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      db_q      <= db_d;
      counter_q <= counter_d;
      ack_q     <= ack_d;
      clear_q   <= bus.clear;
    end
  end

  assign bus.counter = counter_q;
  assign bus.ack     = ack_q;

endmodule

// File: tb/tb_dbctr_core.sv
// Self-checking bench for dbctr_core: directed scenarios plus randomized stimulus against a
// run-length reference model.
module tb_dbctr_core;

  localparam int unsigned Hold  = 4;
  localparam int unsigned Width = 4;

  logic clock;
  logic reset_n;

  dbctr_core_if #(.WIDTH(Width)) bus ();

  dbctr_core #(
    .HOLD_CYCLES (Hold),
    .WIDTH       (Width)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: length of the current high run of each button (unbounded), the counter
  // modulo 2^Width, the ack due after the last edge and the previous clear sample.
  int          run [3];
  int          m_cnt;
  bit          m_ack;
  bit          m_clr_prev;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) run[i] = 0;
    m_cnt      = 0;
    m_ack      = 1'b0;
    m_clr_prev = 1'b0;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit l, input bit c, input int v);
    bit b [3];
    bit f [3];
    b[0] = u; b[1] = d; b[2] = l;
    m_ack = 1'b0;
    if (c) begin
      for (int i = 0; i < 3; i++) run[i] = 0;
      m_cnt = 0;
      m_ack = !m_clr_prev;
    end else begin
      for (int i = 0; i < 3; i++) begin
        run[i] = b[i] ? run[i] + 1 : 0;
        f[i]   = (run[i] == Hold);
      end
      if (f[2]) begin
        m_cnt = v; m_ack = 1'b1;
      end else if (f[0]) begin
        m_cnt = (m_cnt + 1) % 16; m_ack = 1'b1;
      end else if (f[1]) begin
        m_cnt = (m_cnt + 15) % 16; m_ack = 1'b1;
      end
    end
    m_clr_prev = c;
  endtask

  // Drive inputs, advance one rising edge, update the model, sample 1 time unit later.
  task automatic tick(input bit u, input bit d, input bit l, input bit c, input int v);
    bus.up    = u;
    bus.down  = d;
    bus.load  = l;
    bus.clear = c;
    bus.value = Width'(v);
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_edge(u, d, l, c, v);
    #1;
  endtask

  task automatic test_reset();
    bus.up = 0; bus.down = 0; bus.load = 0; bus.clear = 0; bus.value = '0;
    reset_n = 1'b0;
    model_reset();
    #13;
    checks++;
    if (bus.counter !== 4'd0) begin
      failures++; $display("FAIL reset_counter: got %0d want 0", bus.counter);
    end
    checks++;
    if (bus.ack !== 1'b0) begin
      failures++; $display("FAIL reset_ack: got %0b want 0", bus.ack);
    end
    @(posedge clock); #2;
    reset_n = 1'b1;
  endtask

  task automatic test_up_basic();
    for (int k = 1; k <= 5; k++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (bus.counter !== ((k >= 4) ? 4'd1 : 4'd0) || bus.ack !== (k == 4)) begin
        failures++;
        $display("FAIL up_basic edge %0d: got cnt=%0d ack=%0b", k, bus.counter, bus.ack);
      end
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_short_then_down();
    for (int k = 1; k <= 3; k++) tick(1, 0, 0, 0, 0);
    checks++;
    if (bus.counter !== 4'd1 || bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL short_up: got cnt=%0d ack=%0b want cnt=1 ack=0", bus.counter, bus.ack);
    end
    for (int k = 1; k <= 10; k++) begin
      tick(0, 1, 0, 0, 0);
      checks++;
      if (bus.counter !== ((k >= 4) ? 4'd0 : 4'd1) || bus.ack !== (k == 4)) begin
        failures++;
        $display("FAIL down_hold edge %0d: got cnt=%0d ack=%0b", k, bus.counter, bus.ack);
      end
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap_load();
    int exp_v [4];
    int btn   [4];
    exp_v = '{15, 14, 15, 0};
    btn   = '{1, 2, 0, 0};
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) tick(btn[s] == 0, btn[s] == 1, btn[s] == 2, 0, 14);
      checks++;
      if (bus.counter !== Width'(exp_v[s]) || bus.ack !== 1'b1) begin
        failures++;
        $display("FAIL wrap_load step %0d: got cnt=%0d ack=%0b want cnt=%0d ack=1",
                 s, bus.counter, bus.ack, exp_v[s]);
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_priority();
    for (int k = 1; k <= 7; k++) begin
      tick(1, 0, 1, 0, 7);
      checks++;
      if (bus.counter !== ((k >= 4) ? 4'd7 : 4'd0) || bus.ack !== (k == 4)) begin
        failures++;
        $display("FAIL prio edge %0d: got cnt=%0d ack=%0b", k, bus.counter, bus.ack);
      end
    end
    for (int k = 1; k <= 4; k++) tick(1, 0, 0, 0, 0);
    checks++;
    if (bus.counter !== 4'd7) begin
      failures++; $display("FAIL prio_up_consumed: got %0d want 7", bus.counter);
    end
    tick(0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) tick(1, 0, 0, 0, 0);
    checks++;
    if (bus.counter !== 4'd8 || bus.ack !== 1'b1) begin
      failures++;
      $display("FAIL prio_repress: got cnt=%0d ack=%0b want cnt=8 ack=1", bus.counter, bus.ack);
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_clear();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1, 0, 0, 1, 0);
      checks++;
      if (bus.counter !== 4'd0 || bus.ack !== (k == 1)) begin
        failures++;
        $display("FAIL clear edge %0d: got cnt=%0d ack=%0b", k, bus.counter, bus.ack);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (bus.counter !== ((k == 4) ? 4'd1 : 4'd0) || bus.ack !== (k == 4)) begin
        failures++;
        $display("FAIL after_clear edge %0d: got cnt=%0d ack=%0b", k, bus.counter, bus.ack);
      end
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 4; k++) tick(0, 0, 1, 0, 5);
    tick(0, 0, 0, 0, 0);
    checks++;
    if (bus.counter !== 4'd5) begin
      failures++; $display("FAIL reset_mid_preload: got %0d want 5", bus.counter);
    end
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.counter !== 4'd0 || bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got cnt=%0d ack=%0b want 0/0", bus.counter, bus.ack);
    end
    tick(0, 1, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(0, 1, 0, 0, 0);
      checks++;
      if (bus.counter !== ((k == 4) ? 4'd15 : 4'd0) || bus.ack !== (k == 4)) begin
        failures++;
        $display("FAIL post_reset_down edge %0d: got cnt=%0d ack=%0b", k, bus.counter, bus.ack);
      end
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit u, d, l, c;
    u = 0; d = 0; l = 0; c = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) u = !u;
      if ($urandom_range(0, 5) == 0) d = !d;
      if ($urandom_range(0, 7) == 0) l = !l;
      if (c) c = ($urandom_range(0, 1) == 0);
      else   c = ($urandom_range(0, 39) == 0);
      tick(u, d, l, c, int'($urandom_range(0, 15)));
      checks++;
      if (bus.counter !== Width'(m_cnt) || bus.ack !== m_ack) begin
        failures++;
        $display("FAIL random cycle %0d: got cnt=%0d ack=%0b want cnt=%0d ack=%0b",
                 n, bus.counter, bus.ack, m_cnt, m_ack);
      end
    end
    tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_up_basic();
    test_short_then_down();
    test_wrap_load();
    test_priority();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
